// File: rtl/biu_slave_buf.sv
// rtl/biu_slave_buf.sv - shared-bus slave front end: request queue toward a local slave, read response back onto the bus
module biu_slave_buf #(
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 32'h0,
  parameter logic [ADDR_WIDTH-1:0]    ADDR_SPAN  = 32'h10,
  parameter int unsigned              FIFO_DEPTH = 4,
  parameter int unsigned              TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0]    ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [ADDR_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  inout  wire  [1:0]            bus_control,
  output logic                  bus_stall,
  output logic                  biu_req_valid,
  input  logic                  biu_req_ready,
  output logic [ADDR_WIDTH-1:0] biu_address,
  output logic [DATA_WIDTH-1:0] biu_data_in,
  output logic                  biu_rnw,
  input  logic                  biu_rsp_valid,
  input  logic [DATA_WIDTH-1:0] biu_data_out,
  output logic                  err_timeout,
  output logic [7:0]            drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

  typedef enum logic [1:0] {IDLE, WAIT_RSP, SEND_RSP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_rnw;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      ahead;
  logic [TMR_W-1:0]      timer;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic cs, full, push, drop, pop, rsp_ok;

  assign cs     = bus_control[0] && ({1'b0, bus_address} >= {1'b0, BASE_ADDR})
                  && ({1'b0, bus_address} < LIMIT);
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign push   = (state == IDLE) && cs && !full;
  assign drop   = (state == IDLE) && cs && full;
  assign pop    = biu_req_valid && biu_req_ready;
  // ahead counts pops still needed before our read leaves the queue
  assign rsp_ok = (state == WAIT_RSP) && (ahead == '0) && biu_rsp_valid;

  assign bus_stall     = full;
  assign biu_req_valid = (count != '0);
  assign biu_address   = q_addr[rd_ptr];
  assign biu_data_in   = q_data[rd_ptr];
  assign biu_rnw       = q_rnw[rd_ptr];

  assign bus_address = (state != IDLE) ? rd_addr : 'z;
  assign bus_data    = (state != IDLE) ? ((state == SEND_RSP) ? rsp_data : '0) : 'z;
  assign bus_control = (state != IDLE) ? {1'b1, state == SEND_RSP} : 2'bzz;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus_address - BASE_ADDR;
      q_data[wr_ptr] <= bus_data;
      q_rnw[wr_ptr]  <= bus_control[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ahead       <= '0;
      timer       <= '0;
      rd_addr     <= '0;
      rsp_data    <= '0;
      err_timeout <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      err_timeout <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      case (state)
        IDLE: begin
          if (push && bus_control[1]) begin
            state   <= WAIT_RSP;
            timer   <= '0;
            rd_addr <= bus_address;
            ahead   <= count + CNT_W'(1) - CNT_W'(pop);
          end
        end
        WAIT_RSP: begin
          if (pop && ahead != '0) ahead <= ahead - CNT_W'(1);
          timer <= timer + TMR_W'(1);
          if (rsp_ok) begin
            rsp_data <= biu_data_out;
            state    <= SEND_RSP;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            rsp_data    <= ERR_DATA;
            err_timeout <= 1'b1;
            state       <= SEND_RSP;
          end
        end
        SEND_RSP: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biu_slave_buf.sv
// tb/tb_biu_slave_buf.sv - scoreboard bench for biu_slave_buf with a queue-level reference model
module tb_biu_slave_buf;

  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] SPAN  = 32'h10;
  localparam int          DEPTH = 4;
  localparam int          TMO   = 16;
  localparam logic [31:0] ERR   = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_drive;
  logic [31:0] tb_addr, tb_data;
  logic [1:0]  tb_ctrl;
  wire  [31:0] bus_address, bus_data;
  wire  [1:0]  bus_control;
  logic        bus_stall, biu_req_valid, biu_req_ready, biu_rnw;
  logic [31:0] biu_address, biu_data_in, biu_data_out;
  logic        biu_rsp_valid, err_timeout;
  logic [7:0]  drop_count;

  assign bus_address = tb_drive ? tb_addr : 'z;
  assign bus_data    = tb_drive ? tb_data : 'z;
  assign bus_control = tb_drive ? tb_ctrl : 2'bzz;

  always #5 clk = ~clk;

  biu_slave_buf dut (
    .clk(clk), .rst(rst),
    .bus_address(bus_address), .bus_data(bus_data), .bus_control(bus_control),
    .bus_stall(bus_stall), .biu_req_valid(biu_req_valid), .biu_req_ready(biu_req_ready),
    .biu_address(biu_address), .biu_data_in(biu_data_in), .biu_rnw(biu_rnw),
    .biu_rsp_valid(biu_rsp_valid), .biu_data_out(biu_data_out),
    .err_timeout(err_timeout), .drop_count(drop_count)
  );

  typedef struct { logic [31:0] off; logic [31:0] data; logic rnw; int id; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } rsp_t;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  int          exp_drop = 0;
  int          push_now = 0, drop_now = 0;
  int          exp_phase = 0;
  int          in_rst = 1, mon_en = 0;
  int          next_id = 0, rd_id = 0;
  logic [31:0] cur_rd_addr = '0;
  int          n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  function automatic bit queued(input int id);
    foreach (exp_req[i]) if (exp_req[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares DUT outputs against the model mid-cycle
  initial begin
    int   cnt;
    req_t h;
    rsp_t r;
    forever begin
      @(posedge clk); #4;
      if (mon_en != 0 && in_rst == 0) begin
        cnt = exp_req.size() - push_now;
        chk("bus_stall", 32'(bus_stall), 32'(cnt == DEPTH));
        chk("req_valid", 32'(biu_req_valid), 32'(cnt != 0));
        chk("drop_count", 32'(drop_count), 32'(exp_drop - drop_now));
        if (cnt != 0 && biu_req_ready) begin
          h = exp_req.pop_front();
          chk("head_addr", biu_address, h.off);
          chk("head_data", biu_data_in, h.data);
          chk("head_rnw", 32'(biu_rnw), 32'(h.rnw));
        end
        if (exp_phase == 1) begin
          chk("wait_ctrl", 32'(bus_control), 32'(2'b10));
          chk("wait_addr", bus_address, cur_rd_addr);
          chk("wait_data", bus_data, 32'h0);
        end else if (exp_phase == 2) begin
          chk("send_ctrl", 32'(bus_control), 32'(2'b11));
          chk("rsp_pending", 32'(exp_rsp.size() != 0), 32'd1);
          if (exp_rsp.size() != 0) begin
            r = exp_rsp.pop_front();
            chk("rsp_data", bus_data, r.data);
            chk("rsp_addr", bus_address, r.addr);
            chk("rsp_err", 32'(err_timeout), 32'(r.err));
          end
        end else if (tb_drive == 1'b0) begin
          chk("idle_no_dv", 32'(bus_control[0] === 1'b1), 32'd0);
        end
        if (exp_phase != 2) chk("err_quiet", 32'(err_timeout), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
    push_now = 0; drop_now = 0; rst = 1'b0; in_rst = 0; biu_rsp_valid = 1'b0;
  endtask

  function automatic logic pick(input int pct);
    return ($urandom_range(99) < 32'(pct));
  endfunction

  task automatic idle(input int n, input int rdy_pct);
    repeat (n) begin
      cyc();
      tb_drive = 1'b0; exp_phase = 0; biu_req_ready = pick(rdy_pct);
    end
  endtask

  task automatic bus_req(input logic [31:0] a, input logic [31:0] d, input logic rnw,
                         input logic dv, input int rdy_pct, output logic rd_pushed);
    req_t e;
    cyc();
    tb_drive = 1'b1; tb_addr = a; tb_data = d; tb_ctrl = {rnw, dv};
    exp_phase = 0; biu_req_ready = pick(rdy_pct);
    rd_pushed = 1'b0;
    if (dv && a >= BASE && a < BASE + SPAN) begin
      if (exp_req.size() < DEPTH) begin
        e.off = a - BASE; e.data = d; e.rnw = rnw; e.id = next_id;
        exp_req.push_back(e);
        push_now = 1;
        if (rnw) begin rd_pushed = 1'b1; rd_id = next_id; cur_rd_addr = a; end
        next_id++;
      end else if (exp_drop < 255) begin
        exp_drop++; drop_now = 1;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int rdy_pct);
    logic unused_rd;
    bus_req(a, d, 1'b0, 1'b1, rdy_pct, unused_rd);
  endtask

  // Slave side: response accepted only once the read has left the queue, within TMO wait cycles
  task automatic do_read(input logic [31:0] a, input int rdy_pct, input int rsp_pct,
                         input int abort_at, input logic [31:0] rdata);
    logic pushed, got;
    rsp_t r;
    int   id;
    bus_req(a, $urandom, 1'b1, 1'b1, rdy_pct, pushed);
    if (!pushed) return;
    id = rd_id; got = 1'b0;
    for (int t = 0; t < TMO && !got; t++) begin
      cyc();
      tb_drive = 1'b0; exp_phase = 1; biu_req_ready = pick(rdy_pct); biu_data_out = rdata;
      if (t == abort_at) begin
        rst = 1'b1; in_rst = 1; exp_phase = 0;
        exp_req.delete(); exp_drop = 0;
        return;
      end
      if (!queued(id)) begin
        if (pick(rsp_pct)) begin biu_rsp_valid = 1'b1; got = 1'b1; end
      end else if (pick(25)) begin
        biu_rsp_valid = 1'b1;
      end
    end
    r.addr = a; r.data = got ? rdata : ERR; r.err = !got;
    exp_rsp.push_back(r);
    cyc();
    tb_drive = 1'b0; exp_phase = 2; biu_req_ready = pick(rdy_pct);
  endtask

  initial begin
    logic        unused_rd;
    int          rdy, k;
    logic [31:0] a;
    rst = 1'b1; tb_drive = 1'b1; tb_addr = '0; tb_data = '0; tb_ctrl = 2'b00;
    biu_req_ready = 1'b0; biu_rsp_valid = 1'b0; biu_data_out = '0;
    repeat (3) @(posedge clk);
    #2; mon_en = 1;
    idle(2, 0);

    // queue three writes, then drain in order
    do_write(32'h4, 32'h1, 0);
    do_write(32'h8, 32'h2, 0);
    do_write(32'hC, 32'h3, 0);
    idle(2, 0);
    idle(4, 100);

    // fill and overflow
    for (int i = 0; i < 5; i++) do_write(32'(4 * (i % 4)), 32'(100 + i), 0);
    idle(2, 0);
    idle(5, 100);

    do_read(32'h0, 100, 100, -1, 32'hA5A5A5A5);
    idle(2, 100);
    do_read(32'h4, 0, 100, -1, 32'h12345678);
    idle(3, 100);

    // span edge and non-valid cycles are not selected
    bus_req(32'h10, 32'h55, 1'b0, 1'b1, 0, unused_rd);
    bus_req(32'h10, 32'h55, 1'b1, 1'b1, 0, unused_rd);
    bus_req(32'h8, 32'h66, 1'b0, 1'b0, 0, unused_rd);
    idle(2, 0);

    // reset while waiting with entries queued
    do_write(32'h4, 32'h77, 0);
    do_write(32'h8, 32'h88, 0);
    do_read(32'hC, 0, 0, 3, 32'h0);
    idle(3, 50);

    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) begin
        k = int'($urandom_range(2));
        rdy = (k == 0) ? 15 : (k == 1) ? 50 : 90;
      end
      k = int'($urandom_range(9));
      a = 32'($urandom_range(15));
      if (k <= 4)      do_write(a, $urandom, rdy);
      else if (k <= 6) do_read(a, rdy, 30, -1, $urandom);
      else if (k == 7) bus_req(32'h10 + 32'($urandom_range(255)), $urandom, 1'($urandom), 1'b1, rdy, unused_rd);
      else if (k == 8) bus_req(a, $urandom, 1'($urandom), 1'b0, rdy, unused_rd);
      else             idle(int'($urandom_range(1, 3)), rdy);
    end
    idle(8, 100);
    chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
